alu_seq_controller: RTL and testbench
=====================================

# alu_seq_controller

Sequencing FSM for the 8-bit ALU's multi-cycle operations: drives the load/shift/add strobes of the A, Q and M registers and the adder/subtractor to perform radix-2 Booth multiplication and non-restoring division. Sits between the ALU top-level opcode decode and the A/Q/M datapath. It observes only the datapath status bits it needs and never touches data buses itself.

## Interface
Parameters:
- N, 8, operand width and iteration count; Q register width is N+1.
- CW, $clog2(N+1), width of the iteration counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- op  in  1  0 = multiply (Booth), 1 = divide (non-restoring); sampled with start.
- booth_bits  in  2  {Q[1], Q[0]} from the Q register (Q[0] is Booth's q[-1]).
- a_sign  in  1  MSB of register A.
- load_a, load_q, load_m  out  1  parallel-load strobes (operand capture; load_a clears A).
- a_wr  out  1  write the adder result into A.
- alu_add, alu_sub  out  1  adder mode select; never both high.
- aq_rshift  out  1  arithmetic right shift of A:Q (A and Q shift together).
- aq_lshift  out  1  left shift of A:Q; the Q left-shift entry is driven 0.
- q_lsb_wr, q_lsb_val  out  1  write q_lsb_val into the quotient LSB (Q[1]).
- count  out  CW  remaining iterations.
- busy  out  1  high from LOAD through FIX inclusive.
- done  out  1  one-cycle pulse in the DONE state.
- err  out  1  one-cycle pulse on a rejected start (see Configuration).

## Operation
- States: IDLE, LOAD, M_EVAL, M_SHIFT, D_SHIFT, D_ADDSUB, D_SETQ, D_FIX, DONE.
- Outputs are decoded from the state register. The add/sub choice in M_EVAL, D_ADDSUB and D_FIX is a combinational function of the current state and of booth_bits/a_sign.
- IDLE: all strobes 0. On start=1, go to LOAD and latch op.
- LOAD: assert load_a, load_q and load_m; set count=N. Next state is M_EVAL if op=0, else D_SHIFT.
- M_EVAL actions by booth_bits:
  - 01: alu_add and a_wr.
  - 10: alu_sub and a_wr.
  - 00 or 11: no strobe.
  - Always go to M_SHIFT.
- M_SHIFT: assert aq_rshift; count decrements. Go to M_EVAL if the decremented count ≠ 0, else DONE.
- D_SHIFT: assert aq_lshift; go to D_ADDSUB.
- D_ADDSUB: a_wr, plus alu_sub if a_sign=0 or alu_add if a_sign=1. Go to D_SETQ.
- D_SETQ: q_lsb_wr with q_lsb_val = ~a_sign (the post-operation sign); count decrements. Go to D_SHIFT if count ≠ 0, else D_FIX.
- D_FIX: if a_sign=1, assert alu_add and a_wr (remainder restore), else no strobe. Always go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- The count never wraps: it decrements only from nonzero values.

## Timing
- Reset values: state IDLE, count 0, every output 0.
- start asserted in IDLE at cycle t: LOAD occurs at t+1.
  - Multiply: done at t+2+2N (t+18 for N=8).
  - Divide: done at t+3+3N (t+27 for N=8).
- Latency is data-independent.
- The first cycle start can be accepted again is the cycle after DONE.
- start while busy or in DONE: ignored, with no err.
- rst mid-operation: the next state is IDLE with all outputs 0, and the partial result is abandoned. rst has priority over a simultaneous start.

## Configuration
- ALU_SEQ_DIV_EN defined: division path present as described above.
- Not defined: D_* states are not compiled.
  - start with op=1 in IDLE stays in IDLE and pulses err for one cycle.
  - Multiply behaviour is unchanged.

## Structure
- Package alu_seq_pkg holds the state enum, the op encodings (OP_MUL=0, OP_DIV=1) and the default N.
- The iteration counter is a natural sub-module, iter_counter, with load/decrement/zero flag.
- The rest of the FSM is a single module.

## Test plan
- Multiply with a behavioural A/Q/M model: M=0x07, Q=0x03, start at t. Required: done at t+18, A:Q[8:1]=0x0015. M_EVAL issues alu_sub exactly once (first bits=10).
- Multiply by a negative operand: M=0x05, Q=0xFE (-2). Required: product 0xFFF6 (-10); the strobe sequence matches the booth_bits transitions.
- Divide: dividend 0x64 (100) by 0x07. Required: done at t+27, quotient 0x0E, remainder 0x02. D_FIX asserts alu_add only if a_sign=1 at FIX.
- rst asserted in the cycle after the 4th M_SHIFT. Required: next cycle IDLE, all outputs 0, count 0. A following start runs a full, correct multiply.
- start pulsed while busy, and start together with rst. Required: neither produces LOAD. done timing is unchanged from the original start.
- Build without ALU_SEQ_DIV_EN and start with op=1. Required: an err pulse for one cycle, busy stays 0, no strobes.

Source files
------------

// File: rtl/alu_seq_controller_pkg.sv
// alu_seq_pkg: the shared definitions for the ALU multi-cycle sequencer.
//   - state_t    : sequencer states. The D_* states exist only when
//                  ALU_SEQ_DIV_EN is defined.
//   - OP_MUL/OP_DIV : encodings of the op input.
//   - N_DEFAULT  : default operand width and iteration count.
// Configuration macro: ALU_SEQ_DIV_EN (enables the division states).
package alu_seq_pkg;

    localparam int   N_DEFAULT = 8;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_M_EVAL,
        S_M_SHIFT,
`ifdef ALU_SEQ_DIV_EN
        S_D_SHIFT,
        S_D_ADDSUB,
        S_D_SETQ,
        S_D_FIX,
`endif
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_seq_controller_if.sv
// alu_seq_controller_if: the bundle between the sequencer and its
// surroundings (opcode decode and the A/Q/M datapath).
//   Requests/status to the sequencer : start, op, booth_bits, a_sign
//   Strobes from the sequencer       : load_a/q/m, a_wr, alu_add, alu_sub,
//                                      aq_rshift, aq_lshift, q_lsb_wr, q_lsb_val
//   Status from the sequencer        : count, busy, done, err
// Modports: master = sequencer side, slave = decode/datapath side.
interface alu_seq_controller_if
    import alu_seq_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N + 1)
);
    logic          start;
    logic          op;
    logic [1:0]    booth_bits;
    logic          a_sign;
    logic          load_a;
    logic          load_q;
    logic          load_m;
    logic          a_wr;
    logic          alu_add;
    logic          alu_sub;
    logic          aq_rshift;
    logic          aq_lshift;
    logic          q_lsb_wr;
    logic          q_lsb_val;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  start, op, booth_bits, a_sign,
        output load_a, load_q, load_m, a_wr, alu_add, alu_sub,
               aq_rshift, aq_lshift, q_lsb_wr, q_lsb_val,
               count, busy, done, err
    );

    modport slave (
        output start, op, booth_bits, a_sign,
        input  load_a, load_q, load_m, a_wr, alu_add, alu_sub,
               aq_rshift, aq_lshift, q_lsb_wr, q_lsb_val,
               count, busy, done, err
    );

endinterface

// File: rtl/alu_seq_controller_iter_counter.sv
// iter_counter: remaining-iteration counter for the sequencer.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load_i    : load N
//   dec_i     : decrement; ignored at zero so the count never wraps
//   count_o   : remaining iterations
//   zero_o    : count is zero once the decrement of this cycle is applied
//               (i.e. count is 0 or 1); the FSM uses it to end the loop
module iter_counter #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CW'(N);
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q <= CW'(1));

endmodule

// File: rtl/alu_seq_controller.sv
// alu_seq_controller: sequencing FSM for Booth multiplication and
// non-restoring division on the A/Q/M datapath.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : alu_seq_controller_if.master (start/op in, datapath status in,
//          strobes, count, busy, done, err out)
// Configuration macro: ALU_SEQ_DIV_EN. When undefined the division states
// are not built and a divide request in IDLE is rejected with an err pulse.
module alu_seq_controller
    import alu_seq_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_seq_controller_if.master   bus
);
    state_t        state_q;
    state_t        state_d;
    logic          err_q;
    logic          err_d;
    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [CW-1:0] cnt_value;
`ifdef ALU_SEQ_DIV_EN
    logic          op_q;
`endif

    logic load_a, load_q, load_m, a_wr, alu_add, alu_sub;
    logic aq_rshift, aq_lshift, q_lsb_wr, q_lsb_val, done;

    iter_counter #(.N(N), .CW(CW)) u_iter_counter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .dec_i   (cnt_dec),
        .count_o (cnt_value),
        .zero_o  (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            op_q    <= OP_MUL;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_DIV_EN
            if (state_q == S_IDLE && bus.start) begin
                op_q <= bus.op;
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        load_a    = 1'b0;
        load_q    = 1'b0;
        load_m    = 1'b0;
        a_wr      = 1'b0;
        alu_add   = 1'b0;
        alu_sub   = 1'b0;
        aq_rshift = 1'b0;
        aq_lshift = 1'b0;
        q_lsb_wr  = 1'b0;
        q_lsb_val = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
`ifdef ALU_SEQ_DIV_EN
                    state_d = S_LOAD;
`else
                    // No divider built: refuse the request and stay idle.
                    if (bus.op == OP_DIV) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
`endif
                end
            end
            S_LOAD: begin
                load_a   = 1'b1;
                load_q   = 1'b1;
                load_m   = 1'b1;
                cnt_load = 1'b1;
`ifdef ALU_SEQ_DIV_EN
                state_d  = (op_q == OP_DIV) ? S_D_SHIFT : S_M_EVAL;
`else
                state_d  = S_M_EVAL;
`endif
            end
            S_M_EVAL: begin
                // Booth recoding of {q[i], q[i-1]}.
                if (bus.booth_bits == 2'b01) begin
                    alu_add = 1'b1;
                    a_wr    = 1'b1;
                end else if (bus.booth_bits == 2'b10) begin
                    alu_sub = 1'b1;
                    a_wr    = 1'b1;
                end
                state_d = S_M_SHIFT;
            end
            S_M_SHIFT: begin
                aq_rshift = 1'b1;
                cnt_dec   = 1'b1;
                state_d   = cnt_zero ? S_DONE : S_M_EVAL;
            end
`ifdef ALU_SEQ_DIV_EN
            S_D_SHIFT: begin
                aq_lshift = 1'b1;
                state_d   = S_D_ADDSUB;
            end
            S_D_ADDSUB: begin
                // Non-restoring step: subtract while the partial remainder
                // is non-negative, add it back in while negative.
                a_wr    = 1'b1;
                alu_sub = ~bus.a_sign;
                alu_add = bus.a_sign;
                state_d = S_D_SETQ;
            end
            S_D_SETQ: begin
                q_lsb_wr  = 1'b1;
                q_lsb_val = ~bus.a_sign;
                cnt_dec   = 1'b1;
                state_d   = cnt_zero ? S_D_FIX : S_D_SHIFT;
            end
            S_D_FIX: begin
                // A negative final remainder is corrected by adding M back.
                if (bus.a_sign) begin
                    alu_add = 1'b1;
                    a_wr    = 1'b1;
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.load_a    = load_a;
    assign bus.load_q    = load_q;
    assign bus.load_m    = load_m;
    assign bus.a_wr      = a_wr;
    assign bus.alu_add   = alu_add;
    assign bus.alu_sub   = alu_sub;
    assign bus.aq_rshift = aq_rshift;
    assign bus.aq_lshift = aq_lshift;
    assign bus.q_lsb_wr  = q_lsb_wr;
    assign bus.q_lsb_val = q_lsb_val;
    assign bus.done      = done;
    assign bus.err       = err_q;
    assign bus.count     = cnt_value;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_alu_seq_controller.sv
// tb_alu_seq_controller: directed bench for alu_seq_controller with a
// behavioural A/Q/M datapath closing the loop on booth_bits and a_sign.
// Honours ALU_SEQ_DIV_EN: the divide test or the rejected-divide test runs.
module tb_alu_seq_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_seq_controller_if #(.N(8)) bus ();

    alu_seq_controller #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural datapath: A (8b), Q (9b, Q[0] = Booth q[-1]), M (8b).
    logic [7:0] ma = '0;
    logic [8:0] mq = '0;
    logic [7:0] mm = '0;
    logic [7:0] opnd_m = '0;
    logic [7:0] opnd_q = '0;

    logic s_load_a = 0, s_load_q = 0, s_load_m = 0, s_a_wr = 0;
    logic s_add = 0, s_sub = 0, s_rsh = 0, s_lsh = 0, s_qw = 0, s_qv = 0;

    assign bus.booth_bits = mq[1:0];
    assign bus.a_sign     = ma[7];

    // Strobes are captured mid-cycle and applied at the next rising edge.
    always @(negedge clk) begin
        s_load_a <= bus.load_a;
        s_load_q <= bus.load_q;
        s_load_m <= bus.load_m;
        s_a_wr   <= bus.a_wr;
        s_add    <= bus.alu_add;
        s_sub    <= bus.alu_sub;
        s_rsh    <= bus.aq_rshift;
        s_lsh    <= bus.aq_lshift;
        s_qw     <= bus.q_lsb_wr;
        s_qv     <= bus.q_lsb_val;
    end

    always @(posedge clk) begin
        if (s_load_a) ma <= '0;
        if (s_load_q) mq <= {opnd_q, 1'b0};
        if (s_load_m) mm <= opnd_m;
        if (s_a_wr)   ma <= s_add ? (ma + mm) : (s_sub ? (ma - mm) : ma);
        if (s_rsh)    {ma, mq} <= {ma[7], ma, mq[8:1]};
        if (s_lsh)    {ma, mq} <= {ma[6:0], mq, 1'b0};
        if (s_qw)     mq[1] <= s_qv;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [9:0] strobes();
        return {bus.load_a, bus.load_q, bus.load_m, bus.a_wr, bus.alu_add,
                bus.alu_sub, bus.aq_rshift, bus.aq_lshift, bus.q_lsb_wr,
                bus.q_lsb_val};
    endfunction

    // Start an operation in cycle t; cycle k is t+k. poke>0 pulses start
    // again in cycle t+poke. Returns the k where done is seen (-1 on timeout).
    task automatic run_op(input logic opv, input logic [7:0] m, input logic [7:0] q,
                          input int poke, output int done_at,
                          output int n_add, output int n_sub);
        opnd_m = m;
        opnd_q = q;
        @(negedge clk);
        bus.op    = opv;
        bus.start = 1'b1;
        done_at = -1;
        n_add   = 0;
        n_sub   = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.start = (k == poke);
            if (bus.alu_add) n_add++;
            if (bus.alu_sub) n_sub++;
            if (bus.done) begin
                done_at = k;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int d, na, ns, shifts;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",    32'(bus.busy), 32'd0);
        check("reset_done",    32'(bus.done), 32'd0);
        check("reset_err",     32'(bus.err), 32'd0);
        check("reset_count",   32'(bus.count), 32'd0);
        check("reset_strobes", 32'(strobes()), 32'd0);

        // 7 * 3 = 21: one subtract (first pair 10) and one add (pair 01).
        run_op(1'b0, 8'h07, 8'h03, 0, d, na, ns);
        check("mul7x3_done_cycle", 32'(d), 32'd18);
        check("mul7x3_product",    32'({ma, mq[8:1]}), 32'h0015);
        check("mul7x3_sub_count",  32'(ns), 32'd1);
        check("mul7x3_add_count",  32'(na), 32'd1);
        @(negedge clk);
        check("mul7x3_idle_after", 32'(bus.busy), 32'd0);

        // 5 * -2 = -10: only the 0->1 transition of Q needs a subtract.
        run_op(1'b0, 8'h05, 8'hFE, 0, d, na, ns);
        check("mul5xm2_done_cycle", 32'(d), 32'd18);
        check("mul5xm2_product",    32'({ma, mq[8:1]}), 32'hFFF6);
        check("mul5xm2_sub_count",  32'(ns), 32'd1);
        check("mul5xm2_add_count",  32'(na), 32'd0);
        @(negedge clk);

        // start pulsed while busy must not disturb the running operation.
        run_op(1'b0, 8'h07, 8'h03, 5, d, na, ns);
        check("busy_start_done_cycle", 32'(d), 32'd18);
        check("busy_start_product",    32'({ma, mq[8:1]}), 32'h0015);
        @(negedge clk);
        check("busy_start_no_reload",  32'(bus.busy), 32'd0);

        // Reset in the cycle after the 4th M_SHIFT.
        opnd_m = 8'h07;
        opnd_q = 8'h03;
        @(negedge clk);
        bus.op    = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        shifts = 0;
        for (int k = 0; k < 40 && shifts < 4; k++) begin
            if (bus.aq_rshift) shifts++;
            if (shifts < 4) @(negedge clk);
        end
        check("rst_mid_reached_4_shifts", 32'(shifts), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy",    32'(bus.busy), 32'd0);
        check("rst_mid_count",   32'(bus.count), 32'd0);
        check("rst_mid_strobes", 32'(strobes()), 32'd0);
        check("rst_mid_done",    32'(bus.done), 32'd0);
        rst = 1'b0;
        run_op(1'b0, 8'h05, 8'hFE, 0, d, na, ns);
        check("after_rst_done_cycle", 32'(d), 32'd18);
        check("after_rst_product",    32'({ma, mq[8:1]}), 32'hFFF6);
        @(negedge clk);

        // start together with rst: reset wins, no LOAD follows.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        @(negedge clk);
        check("rst_start_busy",   32'(bus.busy), 32'd0);
        check("rst_start_load_a", 32'(bus.load_a), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_still_idle", 32'(bus.busy), 32'd0);

`ifdef ALU_SEQ_DIV_EN
        // 100 / 7 = 14 remainder 2.
        run_op(1'b1, 8'h07, 8'h64, 0, d, na, ns);
        check("div_done_cycle", 32'(d), 32'd27);
        check("div_quotient",   32'(mq[8:1]), 32'h0E);
        check("div_remainder",  32'(ma), 32'h02);
        @(negedge clk);
        check("div_idle_after", 32'(bus.busy), 32'd0);
`else
        // Divide request without a divider: err for one cycle, nothing else.
        @(negedge clk);
        bus.op    = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("nodiv_err_pulse", 32'(bus.err), 32'd1);
        check("nodiv_busy",      32'(bus.busy), 32'd0);
        check("nodiv_strobes",   32'(strobes()), 32'd0);
        @(negedge clk);
        check("nodiv_err_cleared", 32'(bus.err), 32'd0);
        check("nodiv_busy_later",  32'(bus.busy), 32'd0);
        check("nodiv_strobes_later", 32'(strobes()), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
